// File: rtl/fft_adapter_pkg.sv
// rtl/fft_adapter_pkg.sv - shared types, constants and helpers for the FFT stream adapter
package fft_adapter_pkg;

  typedef enum logic {
    CFG_SEND = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam logic [7:0] CFG_DEFAULT = 8'h01;

  // Round half up by dropping s LSBs, then clamp to a signed out_w-bit range.
  function automatic logic signed [31:0] round_sat_fn(input logic signed [31:0] x,
                                                      input int s, input int out_w);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r = x;
    if (s > 0) r = (x + (32'sd1 <<< (s - 1))) >>> s;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/fft_axis_adapter_round_sat.sv
// rtl/fft_axis_adapter_round_sat.sv - combinational round-and-saturate of one core component
module round_sat
  import fft_adapter_pkg::*;
#(
  parameter int CORE_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic [CORE_W-1:0] x,
  output logic [OUT_W-1:0]  y
);

  assign y = OUT_W'(round_sat_fn(32'(signed'(x)), CORE_W - OUT_W, OUT_W));

endmodule

// File: rtl/fft_axis_adapter.sv
// rtl/fft_axis_adapter.sv - stream adapter between user samples and an FFT core
module fft_axis_adapter #(
  parameter int IN_W      = 8,
  parameter int CORE_W    = 16,
  parameter int OUT_W     = 8,
  parameter int NFFT_LOG2 = 3,
  parameter int CFG_W     = 8,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(fft_adapter_pkg::CFG_DEFAULT)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  input  logic                out_sel,
  output logic [2*CORE_W-1:0] core_s_tdata,
  output logic                core_s_tvalid,
  output logic                core_s_tlast,
  input  logic                core_s_tready,
  output logic [CFG_W-1:0]    core_cfg_tdata,
  output logic                core_cfg_tvalid,
  input  logic                core_cfg_tready,
  input  logic [2*CORE_W-1:0] core_m_tdata,
  input  logic                core_m_tvalid,
  input  logic                core_m_tlast,
  output logic                core_m_tready,
  output logic [7:0]          err_last_early,
  output logic [7:0]          err_last_missing,
  output logic [7:0]          frames_out
);
  import fft_adapter_pkg::*;

  state_t               state, state_nxt;
  logic [CFG_W-1:0]     cfg_pend;
  logic [NFFT_LOG2-1:0] frame_cnt;
  logic                 cnt_last;
  logic                 in_hs;
  logic                 cfg_hs;
  logic                 core_m_hs;
  logic [CORE_W-1:0]    sel_x;
  logic [OUT_W-1:0]     conv_x;

  assign cnt_last  = &frame_cnt;
  assign in_hs     = in_valid && in_ready;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign core_m_hs = core_m_tvalid && core_m_tready;

  assign core_s_tdata   = {{CORE_W{1'b0}}, CORE_W'(signed'(in_data))};
  assign core_s_tvalid  = in_valid && (state == RUN);
  assign core_s_tlast   = cnt_last;
  assign core_cfg_tdata = cfg_pend;

  // Reconfiguration is only taken on an idle frame boundary so the core never sees a split frame.
  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    cfg_ready       = 1'b0;
    core_cfg_tvalid = 1'b0;
    case (state)
      CFG_SEND: begin
        core_cfg_tvalid = 1'b1;
        if (core_cfg_tready) state_nxt = RUN;
      end
      RUN: begin
        in_ready  = core_s_tready;
        cfg_ready = (frame_cnt == '0) && !(in_valid && core_s_tready);
        if (cfg_valid && cfg_ready) state_nxt = CFG_SEND;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= CFG_SEND;
      cfg_pend         <= CFG_DEFAULT;
      frame_cnt        <= '0;
      err_last_early   <= '0;
      err_last_missing <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_hs) cfg_pend <= cfg_data;
      if (in_hs) begin
        frame_cnt <= frame_cnt + NFFT_LOG2'(1);
        if (in_last && !cnt_last) err_last_early <= sat_inc8(err_last_early);
        if (!in_last && cnt_last) err_last_missing <= sat_inc8(err_last_missing);
      end
    end
  end

  assign sel_x = out_sel ? core_m_tdata[2*CORE_W-1:CORE_W] : core_m_tdata[CORE_W-1:0];

  round_sat #(
    .CORE_W(CORE_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .x(sel_x),
    .y(conv_x)
  );

  assign core_m_tready = !out_valid || out_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frames_out <= '0;
    end else begin
      if (core_m_hs) begin
        out_valid <= 1'b1;
        out_data  <= conv_x;
        out_last  <= core_m_tlast;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_last) frames_out <= sat_inc8(frames_out);
    end
  end

endmodule
